mem_arbiter: RTL and testbench

//   Owns the single byte-wide RAM port. Shares it between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM port arbiter between instruction fetch and the MEM stage.
// Optional build macro IO_STALL_EN adds io_buffer_full_i write stalling for the 0x3xxxx I/O window.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
`ifdef IO_STALL_EN
  input  logic              io_buffer_full_i,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d, last_a_q, cur_a;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              done_any, accept_mem, accept_if, stall, rd_busy, last_rd;
  logic [1:0]        rd_byte;

  assign cur_a = addr_q + ADDR_W'(cnt_q);

`ifdef IO_STALL_EN
  assign stall = (state_q == MEM_WR) && (cur_a[17:16] == 2'b11) && io_buffer_full_i;
`else
  assign stall = 1'b0;
`endif

  // A flush arriving in the done cycle still kills the fetch result.
  assign if_done_o   = if_done_q & ~if_flush_i;
  assign mem_done_o  = mem_done_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;

  assign done_any   = if_done_o | mem_done_q;
  assign accept_mem = (state_q == IDLE) && !done_any && mem_req_i;
  assign accept_if  = (state_q == IDLE) && !done_any && !mem_req_i && if_req_i && !if_flush_i;
  assign rd_busy    = (state_q == IF_RD) || (state_q == MEM_RD);
  assign last_rd    = rd_busy && (cnt_q == n_q);
  assign rd_byte    = cnt_q[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_mem)     state_d = mem_wr_i ? MEM_WR : MEM_RD;
        else if (accept_if) state_d = IF_RD;
      end
      IF_RD:   if (if_flush_i || last_rd) state_d = IDLE;
      MEM_RD:  if (last_rd) state_d = IDLE;
      MEM_WR:  if (!stall && (cnt_q == n_q - 3'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_a_o    = last_a_q;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'h00;
    if ((rd_busy && (cnt_q < n_q)) || (state_q == MEM_WR)) ram_a_o = cur_a;
    if (state_q == MEM_WR) begin
      ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
      ram_wr_o   = !stall && !rst;
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if (accept_mem || accept_if) begin
      cnt_d   = 3'd0;
      buf_d   = 32'h0;
      addr_d  = accept_mem ? mem_addr_i : if_addr_i;
      wdata_d = mem_wdata_i;
      n_d     = 3'd4;
      if (accept_mem) begin
        case (mem_len_i)
          2'd0:    n_d = 3'd1;
          2'd1:    n_d = 3'd2;
          default: n_d = 3'd4;
        endcase
      end
    end
    // Read data lags its address by a cycle, so byte i lands while the counter reads i+1.
    if (rd_busy && !((state_q == IF_RD) && if_flush_i)) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q != 3'd0) buf_d[{rd_byte, 3'b000} +: 8] = ram_din_i;
      if (last_rd) begin
        if (state_q == IF_RD) begin
          if_done_d = 1'b1;
          if_data_d = buf_d;
        end else begin
          mem_done_d  = 1'b1;
          mem_rdata_d = buf_d;
        end
      end
    end
    if ((state_q == MEM_WR) && !stall) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == n_q - 3'd1) mem_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      addr_q      <= '0;
      last_a_q    <= '0;
      wdata_q     <= 32'h0;
      buf_q       <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      last_a_q    <= ram_a_o;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a reactive RAM and a byte-level memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i = 1'b0, if_flush_i = 1'b0, mem_req_i = 1'b0, mem_wr_i = 1'b0;
  logic [31:0] if_addr_i = 32'h0, mem_addr_i = 32'h0, mem_wdata_i = 32'h0;
  logic [1:0]  mem_len_i = 2'd0;
  logic        io_full = 1'b0;
  logic [31:0] if_data_o, mem_rdata_o, ram_a_o;
  logic        if_done_o, mem_done_o, ram_wr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  exp_mem [logic [31:0]];

  logic [31:0] tr_a [64];
  logic        tr_wr [64], tr_ifd [64], tr_md [64];
  logic [31:0] tr_ifdata [64], tr_mdata [64];
  int          tr_n = 0;
  int          flush_at = -1, rst_at = -1, full_from = -1, full_to = -1;

  mem_arbiter #(.ADDR_W(32)) dut (
`ifdef IO_STALL_EN
    .io_buffer_full_i(io_full),
`endif
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
  endfunction

  always @(posedge clk) ram_din_i <= ram_rd(ram_a_o);
  always @(posedge clk) if (ram_wr_o) ram_mem[ram_a_o] = ram_dout_o;

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram_mem[a] = b;
    exp_mem[a] = b;
  endtask

  // Trace n cycles; k indexes the cycle whose inputs were applied just before it (c_i is k = i+1).
  task automatic run(input int n);
    logic drop_if, drop_m;
    tr_n = n;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tr_a[k] = ram_a_o;       tr_wr[k] = ram_wr_o;
      tr_ifd[k] = if_done_o;   tr_md[k] = mem_done_o;
      tr_ifdata[k] = if_data_o; tr_mdata[k] = mem_rdata_o;
      drop_if = if_done_o;
      drop_m  = mem_done_o;
      @(posedge clk); #1;
      if (drop_if) if_req_i = 1'b0;
      if (drop_m)  mem_req_i = 1'b0;
      if_flush_i = (k + 1 == flush_at);
      if (k + 1 == flush_at) if_req_i = 1'b0;
      rst = (k + 1 == rst_at);
      if (k + 1 == rst_at) mem_req_i = 1'b0;
      io_full = (k + 1 >= full_from) && (k + 1 <= full_to);
    end
    flush_at = -1; rst_at = -1; full_from = -1; full_to = -1;
    if_flush_i = 1'b0; rst = 1'b0; io_full = 1'b0;
  endtask

  function automatic int first_if();
    for (int k = 0; k < tr_n; k++) if (tr_ifd[k]) return k;
    return -1;
  endfunction

  function automatic int first_m();
    for (int k = 0; k < tr_n; k++) if (tr_md[k]) return k;
    return -1;
  endfunction

  function automatic int wr_sum(input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi && k < tr_n; k++) s += int'(tr_wr[k]);
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({if_done_o, mem_done_o, ram_wr_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {if_done_o, mem_done_o, ram_wr_o}); end
    n_cmp++; if (ram_a_o !== 32'h0 || ram_dout_o !== 8'h0) begin n_err++; $display("FAIL reset_ram: got a=%h d=%h expected 0", ram_a_o, ram_dout_o); end
    n_cmp++; if (if_data_o !== 32'h0 || mem_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h %h expected 0", if_data_o, mem_rdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    int d;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    if_req_i = 1'b1; if_addr_i = 32'h100;
    run(10);
    d = first_if();
    n_cmp++; if (d !== 6) begin n_err++; $display("FAIL if_latency: got %0d expected 6", d); end
    n_cmp++; if (tr_ifdata[6] !== 32'h00000513) begin n_err++; $display("FAIL if_data: got %h expected 00000513", tr_ifdata[6]); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (tr_a[i+1] !== 32'h100 + i) begin n_err++; $display("FAIL if_addr%0d: got %h expected %h", i, tr_a[i+1], 32'h100 + i); end
    end
    n_cmp++; if (tr_a[5] !== 32'h103) begin n_err++; $display("FAIL if_addr_hold: got %h expected 103", tr_a[5]); end
  endtask

  task automatic test_mem_store();
    int d;
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h1000; mem_wdata_i = 32'hDEADBEEF;
    run(10);
    d = first_m();
    n_cmp++; if (d !== 5) begin n_err++; $display("FAIL sw_latency: got %0d expected 5", d); end
    n_cmp++; if (wr_sum(0, 9) !== 4) begin n_err++; $display("FAIL sw_wr_count: got %0d expected 4", wr_sum(0, 9)); end
    n_cmp++; if ({ram_rd(32'h1003), ram_rd(32'h1002), ram_rd(32'h1001), ram_rd(32'h1000)} !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sw_bytes: got %h%h%h%h expected DEADBEEF", ram_rd(32'h1003), ram_rd(32'h1002), ram_rd(32'h1001), ram_rd(32'h1000));
    end
    for (int i = 0; i < 4; i++) exp_mem[32'h1000 + i] = ram_rd(32'h1000 + i);
  endtask

  task automatic test_priority();
    int dm, di;
    logic [31:0] e;
    preload(32'h20, 8'h80);
    e = {exp_rd(32'h203), exp_rd(32'h202), exp_rd(32'h201), exp_rd(32'h200)};
    if_req_i = 1'b1; if_addr_i = 32'h200;
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_len_i = 2'd0; mem_addr_i = 32'h20;
    run(16);
    dm = first_m(); di = first_if();
    n_cmp++; if (dm !== 3) begin n_err++; $display("FAIL prio_mem_latency: got %0d expected 3", dm); end
    n_cmp++; if (tr_mdata[3] !== 32'h00000080) begin n_err++; $display("FAIL prio_lb_data: got %h expected 00000080", tr_mdata[3]); end
    n_cmp++; if (tr_a[4] !== 32'h20 || tr_a[5] !== 32'h200) begin n_err++; $display("FAIL prio_if_start: got %h,%h expected 20,200", tr_a[4], tr_a[5]); end
    n_cmp++; if (di !== 10) begin n_err++; $display("FAIL prio_if_latency: got %0d expected 10", di); end
    n_cmp++; if (tr_ifdata[10] !== e) begin n_err++; $display("FAIL prio_if_data: got %h expected %h", tr_ifdata[10], e); end
  endtask

  task automatic test_wrap();
    int d;
    preload(32'hFFFFFFFF, 8'h34); preload(32'h0, 8'h12);
    mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_len_i = 2'd1; mem_addr_i = 32'hFFFFFFFF;
    run(8);
    d = first_m();
    n_cmp++; if (tr_a[1] !== 32'hFFFFFFFF || tr_a[2] !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h,%h expected FFFFFFFF,00000000", tr_a[1], tr_a[2]); end
    n_cmp++; if (d !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d expected 4", d); end
    n_cmp++; if (tr_mdata[4] !== 32'h00001234) begin n_err++; $display("FAIL wrap_data: got %h expected 00001234", tr_mdata[4]); end
  endtask

  task automatic test_flush_reset();
    logic [7:0] b1;
    if_req_i = 1'b1; if_addr_i = 32'h300; flush_at = 3;
    run(8);
    n_cmp++; if (first_if() !== -1) begin n_err++; $display("FAIL flush_done: got done at %0d expected none", first_if()); end
    n_cmp++; if (tr_a[3] !== 32'h302 || tr_a[4] !== 32'h302) begin n_err++; $display("FAIL flush_idle: got %h,%h expected 302,302", tr_a[3], tr_a[4]); end
    b1 = ram_rd(32'h2001);
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h2000; mem_wdata_i = 32'h11223344; rst_at = 2;
    run(8);
    n_cmp++; if (wr_sum(0, 7) !== 1) begin n_err++; $display("FAIL rst_wr_count: got %0d expected 1", wr_sum(0, 7)); end
    n_cmp++; if (ram_rd(32'h2000) !== 8'h44 || ram_rd(32'h2001) !== b1) begin n_err++; $display("FAIL rst_bytes: got %h,%h expected 44,%h", ram_rd(32'h2000), ram_rd(32'h2001), b1); end
    n_cmp++; if (first_m() !== -1) begin n_err++; $display("FAIL rst_done: got done at %0d expected none", first_m()); end
    exp_mem[32'h2000] = 8'h44;
  endtask

  task automatic test_io_stall();
    int d;
    mem_req_i = 1'b1; mem_wr_i = 1'b1; mem_len_i = 2'd0; mem_addr_i = 32'h30000; mem_wdata_i = 32'h000000A7;
    full_from = 1; full_to = 3;
    run(10);
    d = first_m();
`ifdef IO_STALL_EN
    n_cmp++; if (wr_sum(1, 3) !== 0 || tr_wr[4] !== 1'b1) begin n_err++; $display("FAIL stall_wr: got held=%0d c3=%b expected 0,1", wr_sum(1, 3), tr_wr[4]); end
    n_cmp++; if (d !== 5) begin n_err++; $display("FAIL stall_done: got %0d expected 5", d); end
`else
    n_cmp++; if (tr_wr[1] !== 1'b1) begin n_err++; $display("FAIL nostall_wr: got %b expected 1", tr_wr[1]); end
    n_cmp++; if (d !== 2) begin n_err++; $display("FAIL nostall_done: got %0d expected 2", d); end
`endif
    n_cmp++; if (ram_rd(32'h30000) !== 8'hA7 || wr_sum(0, 9) !== 1) begin n_err++; $display("FAIL stall_byte: got %h/%0d expected a7/1", ram_rd(32'h30000), wr_sum(0, 9)); end
    exp_mem[32'h30000] = 8'hA7;
  endtask

  task automatic test_random();
    int kind, nb, d, exp_lat, nw;
    logic [31:0] a, wd, exp_data, got;
    logic [1:0] len;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + $urandom_range(0, 3) : 32'h4000 + $urandom_range(0, 255);
      len = 2'($urandom_range(0, 3));
      wd = $urandom;
      nb = (kind == 0 || len >= 2) ? 4 : (len == 2'd1 ? 2 : 1);
      exp_data = 32'h0;
      for (int i = 0; i < nb; i++) exp_data[8*i +: 8] = exp_rd(a + i);
      if (kind == 0) begin
        if_req_i = 1'b1; if_addr_i = a;
      end else begin
        mem_req_i = 1'b1; mem_wr_i = (kind == 2); mem_len_i = len; mem_addr_i = a; mem_wdata_i = wd;
      end
      run(10);
      if_req_i = 1'b0; mem_req_i = 1'b0;
      d = (kind == 0) ? first_if() : first_m();
      exp_lat = (kind == 2) ? nb + 1 : nb + 2;
      nw = wr_sum(0, 9);
      n_cmp++; if (d !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d", t, d, exp_lat); end
      n_cmp++; if (nw !== ((kind == 2) ? nb : 0)) begin n_err++; $display("FAIL rnd%0d_wr_count: got %0d expected %0d", t, nw, (kind == 2) ? nb : 0); end
      if (kind == 2) begin
        for (int i = 0; i < nb; i++) exp_mem[a + i] = wd[8*i +: 8];
        got = 32'h0; exp_data = 32'h0;
        for (int i = 0; i < nb; i++) begin got[8*i +: 8] = ram_rd(a + i); exp_data[8*i +: 8] = exp_mem[a + i]; end
        n_cmp++; if (got !== exp_data) begin n_err++; $display("FAIL rnd%0d_store: got %h expected %h", t, got, exp_data); end
      end else begin
        got = (kind == 0) ? tr_ifdata[(d < 0) ? 0 : d] : tr_mdata[(d < 0) ? 0 : d];
        n_cmp++; if (got !== exp_data) begin n_err++; $display("FAIL rnd%0d_load: got %h expected %h", t, got, exp_data); end
      end
      run(2);
    end
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_mem_store();
    test_priority();
    test_wrap();
    test_flush_reset();
    test_io_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
